// File: rtl/door_plant_model.sv
// Behavioural door mechanism: turns motor commands into travel, limit switches and faults.
// Optional reversal dead-time is enabled by defining DOOR_DEADTIME_EN.
module door_plant_model #(
  parameter int POS_W    = 8,
  parameter int TRAVEL   = 16,
  parameter int STEP_DIV = 4,
  parameter int DEAD_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ma,
  input  logic             mc,
  input  logic             obst,
  output logic             la,
  output logic             lc,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             fault,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_CLOSED   = 3'd0,
    S_OPENING  = 3'd1,
    S_OPEN     = 3'd2,
    S_CLOSING  = 3'd3,
    S_HALTED   = 3'd4,
    S_FAULT    = 3'd5,
    S_REV_WAIT = 3'd6
  } door_state_t;

  localparam int               PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [POS_W-1:0] POS_OPEN = POS_W'(TRAVEL);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  door_state_t      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             cmd_open, cmd_close, cmd_idle, cmd_bad;
  logic             in_motion, step;

  assign cmd_open  = ma & ~mc;
  assign cmd_close = mc & ~ma;
  assign cmd_idle  = ~ma & ~mc;
  assign cmd_bad   = ma & mc;
  assign in_motion = (state_q == S_OPENING) || (state_q == S_CLOSING);

  // Resting state for a stopped door, chosen from where it actually is.
  function automatic door_state_t settle(input logic [POS_W-1:0] p);
    if (p == '0)            return S_CLOSED;
    else if (p == POS_OPEN) return S_OPEN;
    else                    return S_HALTED;
  endfunction

  // Starting a move at the target limit lands directly in the resting state.
  function automatic door_state_t go_open(input logic [POS_W-1:0] p);
    return (p == POS_OPEN) ? S_OPEN : S_OPENING;
  endfunction

  function automatic door_state_t go_close(input logic [POS_W-1:0] p);
    return (p == '0) ? S_CLOSED : S_CLOSING;
  endfunction

`ifdef DOOR_DEADTIME_EN
  localparam int               DEAD_W    = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);

  logic [DEAD_W-1:0] dead_q, dead_d;

  always_comb begin
    dead_d = dead_q;
    if (state_d != state_q)
      dead_d = '0;
    else if (state_q == S_REV_WAIT)
      dead_d = dead_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dead_q <= '0;
    else
      dead_q <= dead_d;
  end
`else
  logic unused_dead_cyc;
  assign unused_dead_cyc = ^DEAD_CYC;
`endif

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    step    = 1'b0;
    if (in_motion && (presc_q == PRE_LAST) && !obst) begin
      if ((state_q == S_OPENING && pos_q != POS_OPEN) || (state_q == S_CLOSING && pos_q != '0))
        step = 1'b1;
    end

    // An illegal command beats everything, including a step that would reach a limit.
    if (cmd_bad) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_CLOSED:  if (cmd_open)  state_d = go_open(pos_q);
        S_OPEN:    if (cmd_close) state_d = go_close(pos_q);
        S_OPENING: begin
          if (step) pos_d = pos_q + 1'b1;
          if (step && pos_d == POS_OPEN) state_d = S_OPEN;
          else if (cmd_idle)             state_d = settle(pos_d);
          else if (cmd_close) begin
`ifdef DOOR_DEADTIME_EN
            state_d = S_REV_WAIT;
`else
            state_d = go_close(pos_d);
`endif
          end
        end
        S_CLOSING: begin
          if (step) pos_d = pos_q - 1'b1;
          if (step && pos_d == '0) state_d = S_CLOSED;
          else if (cmd_idle)       state_d = settle(pos_d);
          else if (cmd_open) begin
`ifdef DOOR_DEADTIME_EN
            state_d = S_REV_WAIT;
`else
            state_d = go_open(pos_d);
`endif
          end
        end
        S_HALTED: begin
          if (cmd_open)       state_d = go_open(pos_q);
          else if (cmd_close) state_d = go_close(pos_q);
        end
        S_FAULT:   if (cmd_idle) state_d = settle(pos_q);
        S_REV_WAIT: begin
`ifdef DOOR_DEADTIME_EN
          if (dead_q == DEAD_LAST) begin
            if (cmd_open)       state_d = go_open(pos_q);
            else if (cmd_close) state_d = go_close(pos_q);
            else                state_d = settle(pos_q);
          end
`else
          state_d = settle(pos_q);
`endif
        end
        default:   state_d = settle(pos_q);
      endcase
    end
  end

  // Prescaler restarts on every state entry and freezes while obstructed.
  always_comb begin
    presc_d = presc_q;
    if (state_d != state_q || step)
      presc_d = '0;
    else if (in_motion && !obst)
      presc_d = presc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLOSED;
      pos_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
    end
  end

  assign la     = (pos_q == POS_OPEN);
  assign lc     = (pos_q == '0);
  assign pos    = pos_q;
  assign moving = in_motion;
  assign fault  = (state_q == S_FAULT);
  assign state  = state_q;

endmodule
